// File: rtl/imem_pkg.sv
// Shared types and default sizing for the single-line instruction buffer responder.
package imem_pkg;

  localparam int          DEF_LINE_WORDS = 4;
  localparam int          IDX_W          = $clog2(DEF_LINE_WORDS);
  localparam int          TAG_W          = 15 - IDX_W;
  localparam logic [15:0] DEF_NOP_INST   = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

endpackage

// File: rtl/imem_line_buf.sv
// One-line instruction buffer: word storage, tag, valid bit,
// combinational hit/read port and a single write port.
module imem_line_buf
  import imem_pkg::*;
#(
  parameter  int LINE_WORDS = DEF_LINE_WORDS,
  localparam int IW         = $clog2(LINE_WORDS),
  localparam int TW         = 15 - IW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [TW-1:0] lk_tag,
  input  logic [IW-1:0] lk_idx,
  output logic          hit,
  output logic [15:0]   rd_data,
  input  logic          tag_ld,
  output logic [TW-1:0] tag_out,
  input  logic          set_valid,
  input  logic          clr_valid,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [15:0]   wr_data
);

  logic [15:0]   line_q [LINE_WORDS];
  logic [15:0]   line_d [LINE_WORDS];
  logic [TW-1:0] tag_q, tag_d;
  logic          valid_q, valid_d;

  always_comb begin
    line_d  = line_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (wr_en)     line_d[wr_idx] = wr_data;
    if (tag_ld)    tag_d = lk_tag;
    if (clr_valid) valid_d = 1'b0;
    if (set_valid) valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  // Data words carry no reset; the valid bit alone guards them.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign hit     = valid_q && (tag_q == lk_tag);
  assign rd_data = line_q[lk_idx];
  assign tag_out = tag_q;

endmodule

// File: rtl/imem_line_responder.sv
// Fetch-side responder: serves hits from one buffered line, refills it on a miss.
// Define IMEM_CWF_EN to fetch the requested word first and bypass it to fetch.
module imem_line_responder
  import imem_pkg::*;
#(
  parameter int          LINE_WORDS = DEF_LINE_WORDS,
  parameter logic [15:0] NOP_INST   = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  input  logic        flush,
  output logic        fetch_valid,
  output logic [15:0] fetch_inst,
  output logic        fetch_stall,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int TW = 15 - IW;

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          unused_addr_lsb;

  assign req_idx         = fetch_addr[IW:1];
  assign req_tag         = fetch_addr[15:IW+1];
  assign unused_addr_lsb = fetch_addr[0];

  state_e        state_q, state_d;
  logic [IW-1:0] word_cnt_q, word_cnt_d;
  logic          abort_q, abort_d;
  logic [IW-1:0] fill_idx;

`ifdef IMEM_CWF_EN
  logic [IW-1:0] start_idx_q, start_idx_d;
  assign fill_idx = start_idx_q + word_cnt_q;
`else
  assign fill_idx = word_cnt_q;
`endif

  logic          buf_hit, tag_ld, set_valid, clr_valid, wr_en;
  logic [15:0]   buf_rd_data;
  logic [TW-1:0] buf_tag;

  imem_line_buf #(.LINE_WORDS(LINE_WORDS)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_tag    (req_tag),
    .lk_idx    (req_idx),
    .hit       (buf_hit),
    .rd_data   (buf_rd_data),
    .tag_ld    (tag_ld),
    .tag_out   (buf_tag),
    .set_valid (set_valid),
    .clr_valid (clr_valid),
    .wr_en     (wr_en),
    .wr_idx    (fill_idx),
    .wr_data   (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    abort_d     = abort_q;
`ifdef IMEM_CWF_EN
    start_idx_d = start_idx_q;
`endif
    fetch_valid = 1'b0;
    fetch_inst  = NOP_INST;
    fetch_stall = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    tag_ld      = 1'b0;
    set_valid   = 1'b0;
    clr_valid   = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          clr_valid = 1'b1;
        end else if (fetch_req && buf_hit) begin
          fetch_valid = 1'b1;
          fetch_inst  = buf_rd_data;
        end else if (fetch_req) begin
          fetch_stall = 1'b1;
          tag_ld      = 1'b1;
          clr_valid   = 1'b1;
          word_cnt_d  = '0;
          abort_d     = 1'b0;
`ifdef IMEM_CWF_EN
          start_idx_d = req_idx;
`endif
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        fetch_stall = 1'b1;
        if (flush) begin
          clr_valid = 1'b1;
          state_d   = IDLE;
        end else begin
          mem_rd   = 1'b1;
          mem_addr = {buf_tag, fill_idx, 1'b0};
          state_d  = WAIT;
        end
      end
      WAIT: begin
        fetch_stall = 1'b1;
        if (flush) abort_d = 1'b1;
        if (mem_rvalid) begin
          wr_en = 1'b1;
          // A flush seen in the return cycle itself aborts just like an earlier one.
          if (abort_q || flush) begin
            clr_valid = 1'b1;
            abort_d   = 1'b0;
            state_d   = IDLE;
          end else if (word_cnt_q == IW'(LINE_WORDS - 1)) begin
            set_valid = 1'b1;
            state_d   = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + IW'(1);
            state_d    = ISSUE;
          end
`ifdef IMEM_CWF_EN
          if (!abort_q && !flush && fetch_req && (word_cnt_q == '0)) begin
            fetch_valid = 1'b1;
            fetch_inst  = mem_rdata;
            fetch_stall = 1'b0;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      abort_q     <= 1'b0;
`ifdef IMEM_CWF_EN
      start_idx_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      abort_q     <= abort_d;
`ifdef IMEM_CWF_EN
      start_idx_q <= start_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_line_responder.sv
// Self-checking bench for imem_line_responder (LINE_WORDS=4, memory latency 2,
// memory data = word address ^ 16'hA5A5). Honours IMEM_CWF_EN when defined.
module tb_imem_line_responder;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        flush;
  logic        fetch_valid;
  logic [15:0] fetch_inst;
  logic        fetch_stall;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  int n_vec = 0;
  int n_err = 0;

`ifdef IMEM_CWF_EN
  localparam int MISS_STALLS = 3;
`else
  localparam int MISS_STALLS = 13;
`endif

  imem_line_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .fetch_stall (fetch_stall),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: answers every strobe two cycles later, logs the addresses asked for.
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [15:0] a1 = '0, a2 = '0;
  logic [15:0] rd_log[$];

  always @(posedge clk) begin
    v1 <= mem_rd;
    a1 <= mem_addr;
    v2 <= v1;
    a2 <= a1;
    if (mem_rd) rd_log.push_back(mem_addr);
  end

  assign mem_rvalid = v2;
  assign mem_rdata  = v2 ? (a2 ^ 16'hA5A5) : 16'h0000;

  function automatic logic [15:0] exp_data(input logic [15:0] addr);
    return {addr[15:1], 1'b0} ^ 16'hA5A5;
  endfunction

  // k-th word address the refill of addr's line should request.
  function automatic logic [15:0] exp_fill_addr(input logic [15:0] addr, input int k);
    int start;
`ifdef IMEM_CWF_EN
    start = int'(addr[2:1]);
`else
    start = 0;
`endif
    return (addr & 16'hFFF8) | 16'(((start + k) % 4) * 2);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic req, input logic [15:0] addr, input logic fl);
    @(posedge clk);
    #1;
    fetch_req  = req;
    fetch_addr = addr;
    flush      = fl;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
  endtask

  // Hold a request until it is answered, counting stalled cycles.
  task automatic doFetch(input logic [15:0] addr, output int stalls,
                         output logic [15:0] inst, output bit timeout);
    stalls  = 0;
    inst    = 16'h0000;
    timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      applyStimulus(1'b1, addr, 1'b0);
      if (fetch_valid) begin
        inst    = fetch_inst;
        timeout = 1'b0;
        break;
      end
      if (fetch_stall) stalls++;
    end
  endtask

  task automatic checkMiss(input string name, input logic [15:0] addr);
    int          stalls;
    logic [15:0] inst;
    bit          to;
    rd_log.delete();
    doFetch(addr, stalls, inst, to);
    checkOutput({name, "_timeout"}, 16'(to), 16'd0);
    checkOutput({name, "_stalls"}, 16'(stalls), 16'(MISS_STALLS));
    checkOutput({name, "_inst"}, inst, exp_data(addr));
    drain(12);
    checkOutput({name, "_nrd"}, 16'(rd_log.size()), 16'd4);
    for (int k = 0; k < 4 && k < rd_log.size(); k++)
      checkOutput({name, "_addr"}, rd_log[k], exp_fill_addr(addr, k));
  endtask

  typedef struct {
    string       name;
    logic        req;
    logic [15:0] addr;
    logic        fl;
    logic        exp_valid;
    logic [15:0] exp_inst;
    logic        exp_stall;
    logic        exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          stalls, rd_seen;
    logic [15:0] inst, ra;
    bit          to, got, m_valid, hit, pick_flush;
    logic [12:0] m_line;
    int          r;

    // Single-cycle checks against the line 0x0010..0x0016 once it is resident.
    vecs[0] = '{"hit_w0",     1'b1, 16'h0010, 1'b0, 1'b1, 16'hA5B5, 1'b0, 1'b0};
    vecs[1] = '{"hit_w1",     1'b1, 16'h0012, 1'b0, 1'b1, 16'hA5B7, 1'b0, 1'b0};
    vecs[2] = '{"hit_odd",    1'b1, 16'h0015, 1'b0, 1'b1, 16'hA5B1, 1'b0, 1'b0};
    vecs[3] = '{"hit_w3",     1'b1, 16'h0016, 1'b0, 1'b1, 16'hA5B3, 1'b0, 1'b0};
    vecs[4] = '{"no_req",     1'b0, 16'h0016, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{"hit_w3_odd", 1'b1, 16'h0017, 1'b0, 1'b1, 16'hA5B3, 1'b0, 1'b0};
    vecs[6] = '{"flush_req",  1'b1, 16'h0014, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 16'h0000;
    flush      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 16'(fetch_valid), 16'd0);
    checkOutput("rst_stall", 16'(fetch_stall), 16'd0);
    checkOutput("rst_mem_rd", 16'(mem_rd), 16'd0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0000);
    checkOutput("rst_inst", fetch_inst, 16'h0000);
    rst_n = 1'b1;

    checkMiss("fill14", 16'h0014);

    rd_log.delete();
    doFetch(16'h0016, stalls, inst, to);
    checkOutput("hit16_timeout", 16'(to), 16'd0);
    checkOutput("hit16_stalls", 16'(stalls), 16'd0);
    checkOutput("hit16_inst", inst, 16'hA5B3);
    checkOutput("hit16_nrd", 16'(rd_log.size()), 16'd0);

    checkMiss("evict20", 16'h0020);
    checkMiss("refill10", 16'h0010);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].req, vecs[i].addr, vecs[i].fl);
      checkOutput({vecs[i].name, "_valid"}, 16'(fetch_valid), 16'(vecs[i].exp_valid));
      checkOutput({vecs[i].name, "_inst"}, fetch_inst, vecs[i].exp_inst);
      checkOutput({vecs[i].name, "_stall"}, 16'(fetch_stall), 16'(vecs[i].exp_stall));
      checkOutput({vecs[i].name, "_rd"}, 16'(mem_rd), 16'(vecs[i].exp_rd));
    end
    checkMiss("after_flush", 16'h0014);

    // Flush while waiting on the second word: its data is consumed, nothing more is read.
    applyStimulus(1'b0, 16'h0000, 1'b1);
    rd_log.delete();
    rd_seen = 0;
    got     = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      applyStimulus(1'b1, 16'h0010, 1'b0);
      if (mem_rd) begin
        rd_seen++;
        if (rd_seen == 2) got = 1'b1;
      end
    end
    checkOutput("abort_setup", 16'(got), 16'd1);
    applyStimulus(1'b0, 16'h0010, 1'b1);
    checkOutput("abort_wait_stall", 16'(fetch_stall), 16'd1);
    drain(6);
    checkOutput("abort_nrd", 16'(rd_log.size()), 16'd2);
    checkOutput("abort_idle_stall", 16'(fetch_stall), 16'd0);
    checkMiss("abort_refill", 16'h0010);

    // Reset in the middle of a refill; the stray return afterwards must be ignored.
    rd_log.delete();
    applyStimulus(1'b1, 16'h0020, 1'b0);
    applyStimulus(1'b1, 16'h0020, 1'b0);
    checkOutput("rstmid_issue", 16'(mem_rd), 16'd1);
    applyStimulus(1'b1, 16'h0020, 1'b0);
    #1;
    rst_n     = 1'b0;
    fetch_req = 1'b0;
    #1;
    checkOutput("rstmid_stall", 16'(fetch_stall), 16'd0);
    checkOutput("rstmid_mem_rd", 16'(mem_rd), 16'd0);
    #1;
    rst_n = 1'b1;
    drain(5);
    checkOutput("rstmid_idle_stall", 16'(fetch_stall), 16'd0);
    checkOutput("rstmid_nrd", 16'(rd_log.size()), 16'd1);
    checkMiss("rstmid_refill", 16'h0020);

    // Randomised traffic against a line-level model: one resident line or none.
    applyStimulus(1'b0, 16'h0000, 1'b1);
    m_valid = 1'b0;
    m_line  = '0;
    for (int it = 0; it < 60; it++) begin
      r  = int'($urandom_range(0, 99));
      ra = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) ra[15] = 1'b1;
      pick_flush = (r >= 55 && r < 80);
      if (r < 55) begin
        hit = m_valid && (m_line == ra[15:3]);
        rd_log.delete();
        doFetch(ra, stalls, inst, to);
        checkOutput("rnd_timeout", 16'(to), 16'd0);
        checkOutput("rnd_stalls", 16'(stalls), hit ? 16'd0 : 16'(MISS_STALLS));
        checkOutput("rnd_inst", inst, exp_data(ra));
        if (hit) begin
          checkOutput("rnd_hit_nrd", 16'(rd_log.size()), 16'd0);
        end else begin
          drain(12);
          m_valid = 1'b1;
          m_line  = ra[15:3];
        end
      end else if (pick_flush) begin
        applyStimulus(r < 70, ra, 1'b1);
        checkOutput("rnd_flush_valid", 16'(fetch_valid), 16'd0);
        checkOutput("rnd_flush_stall", 16'(fetch_stall), 16'd0);
        checkOutput("rnd_flush_rd", 16'(mem_rd), 16'd0);
        m_valid = 1'b0;
      end else begin
        applyStimulus(1'b0, ra, 1'b0);
        checkOutput("rnd_idle_valid", 16'(fetch_valid), 16'd0);
        checkOutput("rnd_idle_stall", 16'(fetch_stall), 16'd0);
        checkOutput("rnd_idle_inst", fetch_inst, 16'h0000);
      end
    end

`ifdef IMEM_CWF_EN
    // Critical word returns first and is bypassed; a follow-on request waits for the line.
    applyStimulus(1'b0, 16'h0000, 1'b1);
    rd_log.delete();
    doFetch(16'h0016, stalls, inst, to);
    checkOutput("cwf_timeout", 16'(to), 16'd0);
    checkOutput("cwf_stalls", 16'(stalls), 16'd3);
    checkOutput("cwf_inst", inst, 16'hA5B3);
    doFetch(16'h0010, stalls, inst, to);
    checkOutput("cwf_next_timeout", 16'(to), 16'd0);
    checkOutput("cwf_next_stalls", 16'(stalls), 16'd9);
    checkOutput("cwf_next_inst", inst, 16'hA5B5);
    checkOutput("cwf_nrd", 16'(rd_log.size()), 16'd4);
    for (int k = 0; k < 4 && k < rd_log.size(); k++)
      checkOutput("cwf_addr", rd_log[k], exp_fill_addr(16'h0016, k));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
